// File: rtl/key_input_ctrl_if.sv
// Push-button bundle for key_input_ctrl: raw active-low KEY lines in, clean per-key events out.
// The master side owns the raw buttons; the slave side (the controller) drives the event outputs.
interface key_input_ctrl_if #(
    parameter int NUM_KEYS = 3
);
    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_repeat;
    logic [NUM_KEYS-1:0] key_event;

    modport master (
        output key_n,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_repeat,
        input  key_event
    );

    modport slave (
        input  key_n,
        output key_level,
        output key_press,
        output key_release,
        output key_repeat,
        output key_event
    );
endinterface

// File: rtl/key_input_ctrl.sv
// Per-key synchronise, debounce, press/release one-shots and DAS auto-repeat for the board KEY lines.
// Auto-repeat is built only when KEY_AUTOREPEAT_EN is defined; otherwise key_repeat is 0 and key_event = key_press.
module key_input_ctrl #(
    parameter int NUM_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int DAS_DELAY_CYCLES  = 8000000,
    parameter int DAS_REPEAT_CYCLES = 2500000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    key_input_ctrl_if.slave  keys
);

    // Counter counts up to DEBOUNCE_CYCLES inclusive, so it needs room for that value.
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

`ifdef KEY_AUTOREPEAT_EN
    localparam int DAS_MAX = (DAS_DELAY_CYCLES > DAS_REPEAT_CYCLES) ? DAS_DELAY_CYCLES : DAS_REPEAT_CYCLES;
    localparam int DAS_W   = $clog2(DAS_MAX);

    typedef enum logic [1:0] {
        DAS_IDLE,
        DAS_DELAY,
        DAS_REPEAT
    } das_state_t;
`endif

    logic [NUM_KEYS-1:0] level_vec;
    logic [NUM_KEYS-1:0] press_vec;
    logic [NUM_KEYS-1:0] release_vec;
    logic [NUM_KEYS-1:0] repeat_vec;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        logic            sync1_reg;
        logic            sync2_reg;
        logic            pressed;
        logic [DB_W-1:0] db_cnt_reg;
        logic            level_reg;
        logic            press_reg;
        logic            release_reg;
        logic            accept;
        logic            rise;
        logic            fall;

        assign pressed = ~sync2_reg;

        // A new level is taken once the difference has been seen on DEBOUNCE_CYCLES+1
        // consecutive edges, giving a raw-edge-to-level latency of 2+DEBOUNCE_CYCLES.
        assign accept = (pressed != level_reg) && (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES));
        assign rise   = accept & ~level_reg;
        assign fall   = accept &  level_reg;

        always_ff @(posedge CLOCK_50 or posedge reset) begin
            if (reset) begin
                sync1_reg   <= 1'b1;
                sync2_reg   <= 1'b1;
                db_cnt_reg  <= '0;
                level_reg   <= 1'b0;
                press_reg   <= 1'b0;
                release_reg <= 1'b0;
            end else begin
                sync1_reg   <= keys.key_n[gi];
                sync2_reg   <= sync1_reg;
                press_reg   <= rise;
                release_reg <= fall;
                if (accept) begin
                    level_reg  <= ~level_reg;
                    db_cnt_reg <= '0;
                end else if (pressed == level_reg) begin
                    db_cnt_reg <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + 1'b1;
                end
            end
        end

        assign level_vec[gi]   = level_reg;
        assign press_vec[gi]   = press_reg;
        assign release_vec[gi] = release_reg;

`ifdef KEY_AUTOREPEAT_EN
        das_state_t       state_reg;
        das_state_t       state_next;
        logic [DAS_W-1:0] das_cnt_reg;
        logic [DAS_W-1:0] das_cnt_next;
        logic             repeat_reg;
        logic             repeat_next;

        always_ff @(posedge CLOCK_50 or posedge reset) begin
            if (reset) begin
                state_reg   <= DAS_IDLE;
                das_cnt_reg <= '0;
                repeat_reg  <= 1'b0;
            end else begin
                state_reg   <= state_next;
                das_cnt_reg <= das_cnt_next;
                repeat_reg  <= repeat_next;
            end
        end

        // DELAY is entered on the same edge that raises key_press, so the first
        // repeat lands exactly DAS_DELAY_CYCLES after the press pulse.
        always_comb begin
            state_next   = state_reg;
            das_cnt_next = das_cnt_reg + 1'b1;
            repeat_next  = 1'b0;
            case (state_reg)
                DAS_IDLE: begin
                    das_cnt_next = '0;
                    if (rise) begin
                        state_next = DAS_DELAY;
                    end
                end
                DAS_DELAY: begin
                    if (das_cnt_reg == DAS_W'(DAS_DELAY_CYCLES - 1)) begin
                        repeat_next  = 1'b1;
                        das_cnt_next = '0;
                        state_next   = DAS_REPEAT;
                    end
                end
                DAS_REPEAT: begin
                    if (das_cnt_reg == DAS_W'(DAS_REPEAT_CYCLES - 1)) begin
                        repeat_next  = 1'b1;
                        das_cnt_next = '0;
                    end
                end
                default: begin
                    state_next   = DAS_IDLE;
                    das_cnt_next = '0;
                end
            endcase
            // Release wins: a repeat due on the release edge is dropped.
            if (fall) begin
                state_next   = DAS_IDLE;
                das_cnt_next = '0;
                repeat_next  = 1'b0;
            end
        end

        assign repeat_vec[gi] = repeat_reg;
`else
        assign repeat_vec[gi] = 1'b0;
`endif
    end

    assign keys.key_level   = level_vec;
    assign keys.key_press   = press_vec;
    assign keys.key_release = release_vec;
    assign keys.key_repeat  = repeat_vec;
    assign keys.key_event   = press_vec | repeat_vec;

endmodule

// File: tb/tb_key_input_ctrl.sv
// Directed bench for key_input_ctrl with DEBOUNCE=4, DAS delay=10, DAS repeat=3.
// Expectations follow the auto-repeat setting of the build (KEY_AUTOREPEAT_EN).
module tb_key_input_ctrl;

`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    typedef struct {
        logic [2:0] key_n;
        logic [2:0] level;
        logic [2:0] press;
        logic [2:0] rel;
        logic [2:0] rpt;
    } vec_t;

    logic CLOCK_50;
    logic reset;
    int   n_vec;
    int   n_miss;
    vec_t tbl[$];

    key_input_ctrl_if #(.NUM_KEYS(3)) kif ();

    key_input_ctrl #(
        .NUM_KEYS         (3),
        .DEBOUNCE_CYCLES  (4),
        .DAS_DELAY_CYCLES (10),
        .DAS_REPEAT_CYCLES(3)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .keys    (kif.slave)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input int idx, input logic [2:0] lv, input logic [2:0] pr,
                         input logic [2:0] rl, input logic [2:0] rp);
        logic [2:0] ev;
        ev = pr | rp;
        n_vec++;
        if ({kif.key_level, kif.key_press, kif.key_release, kif.key_repeat, kif.key_event} !== {lv, pr, rl, rp, ev}) begin
            n_miss++;
            $display("FAIL %s[%0d]: got lvl=%b prs=%b rel=%b rpt=%b evt=%b, want lvl=%b prs=%b rel=%b rpt=%b evt=%b",
                     tag, idx, kif.key_level, kif.key_press, kif.key_release, kif.key_repeat, kif.key_event,
                     lv, pr, rl, rp, ev);
        end else begin
            $display("ok %s[%0d] key_n=%b lvl=%b prs=%b rel=%b rpt=%b evt=%b",
                     tag, idx, kif.key_n, lv, pr, rl, rp, ev);
        end
    endtask

    // Inputs are changed 1 time unit after a rising edge; index i is the state after edge i.
    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            kif.key_n = tbl[i].key_n;
            @(posedge CLOCK_50);
            #1;
            check(tag, i, tbl[i].level, tbl[i].press, tbl[i].rel, tbl[i].rpt);
        end
        tbl.delete();
    endtask

    function automatic vec_t mk(input logic [2:0] kn, input logic [2:0] lv, input logic [2:0] pr,
                                input logic [2:0] rl, input logic [2:0] rp);
        vec_t v;
        v.key_n = kn; v.level = lv; v.press = pr; v.rel = rl; v.rpt = rp;
        return v;
    endfunction

    initial begin
        vec_t v;
        n_vec  = 0;
        n_miss = 0;
        reset  = 1'b1;
        kif.key_n = 3'b111;

        // Reset held 5 cycles, then 50 idle cycles with no activity.
        for (int i = 0; i < 5; i++) begin
            @(posedge CLOCK_50);
            #1;
            check("reset", i, 3'b000, 3'b000, 3'b000, 3'b000);
        end
        reset = 1'b0;
        for (int i = 0; i < 50; i++) tbl.push_back(mk(3'b111, 3'b000, 3'b000, 3'b000, 3'b000));
        run_table("idle");

        // Glitch of 3 cycles on key 1 must be rejected.
        for (int i = 0; i < 15; i++) tbl.push_back(mk((i < 3) ? 3'b101 : 3'b111, 3'b000, 3'b000, 3'b000, 3'b000));
        run_table("glitch");

        // Key 0 held for 40 sampled cycles: level at 6, repeats 16,19,..,43; release at 46 with the
        // repeat that would have been due there suppressed.
        for (int i = 0; i < 52; i++) begin
            v = mk((i < 40) ? 3'b110 : 3'b111, 3'b000, 3'b000, 3'b000, 3'b000);
            v.level[0] = (i >= 6) && (i < 46);
            v.press[0] = (i == 6);
            v.rel[0]   = (i == 46);
            v.rpt[0]   = AR && (i >= 16) && (i < 46) && (((i - 16) % 3) == 0);
            tbl.push_back(v);
        end
        run_table("hold");

        // Key 2 released while still in the DAS delay (release sampled 3 cycles after press):
        // release pulse 6 cycles after that sample, and no repeat at press+10 or later.
        for (int i = 0; i < 30; i++) begin
            v = mk((i < 9) ? 3'b011 : 3'b111, 3'b000, 3'b000, 3'b000, 3'b000);
            v.level[2] = (i >= 6) && (i < 15);
            v.press[2] = (i == 6);
            v.rel[2]   = (i == 15);
            tbl.push_back(v);
        end
        run_table("rel_delay");

        // All keys at once, then reset asserted mid-hold at cycle 12.
        kif.key_n = 3'b000;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLOCK_50);
            #1;
            check("simul", i, (i >= 6) ? 3'b111 : 3'b000, (i == 6) ? 3'b111 : 3'b000, 3'b000, 3'b000);
        end
        reset = 1'b1;
        #1;
        check("rst_mid", 0, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int i = 1; i < 3; i++) begin
            @(posedge CLOCK_50);
            #1;
            check("rst_mid", i, 3'b000, 3'b000, 3'b000, 3'b000);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLOCK_50);
            #1;
            check("post_rst", i, (i >= 6) ? 3'b111 : 3'b000, (i == 6) ? 3'b111 : 3'b000, 3'b000, 3'b000);
        end
        kif.key_n = 3'b111;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLOCK_50);
            #1;
            check("all_rel", i, (i < 6) ? 3'b111 : 3'b000, 3'b000, (i == 6) ? 3'b111 : 3'b000, 3'b000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
